// File: rtl/data_mem_arbiter_if.sv
// Requester-side and RAM-side bus of the shared data memory arbiter.
// Port k's fields live in packed slice k of each per-port vector.
interface data_mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                                  prio0_i;
    logic [NUM_PORTS-1:0]                  req_i;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i;
    logic [NUM_PORTS-1:0]                  we_i;
    logic [NUM_PORTS-1:0][BE_W-1:0]        be_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i;
    logic [NUM_PORTS-1:0]                  gnt_o;
    logic [NUM_PORTS-1:0]                  rvalid_o;
    logic [DATA_WIDTH-1:0]                 rdata_o;
    logic                                  mem_req_o;
    logic [ADDR_WIDTH-1:0]                 mem_addr_o;
    logic                                  mem_we_o;
    logic [BE_W-1:0]                       mem_be_o;
    logic [DATA_WIDTH-1:0]                 mem_wdata_o;
    logic [DATA_WIDTH-1:0]                 mem_rdata_i;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]   stall_cnt_o;

    modport slave (
        input  prio0_i, req_i, addr_i, we_i, be_i, wdata_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o, mem_we_o,
               mem_be_o, mem_wdata_o, stall_cnt_o
    );

    modport master (
        output prio0_i, req_i, addr_i, we_i, be_i, wdata_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o, mem_we_o,
               mem_be_o, mem_wdata_o, stall_cnt_o
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency RAM between
// NUM_PORTS requesters, with port-0 priority override and stall counters.
module data_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [PTR_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]                 rvalid_q;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [NUM_PORTS-1:0]                 gnt;
    logic [PTR_W-1:0]                     gidx;
    logic                                 any_gnt;
    logic [PTR_W:0]                       scan;

    // Scan from rr_ptr upward with wrap; extra bit keeps the sum from overflowing.
    always_comb begin
        gnt     = '0;
        gidx    = '0;
        any_gnt = 1'b0;
        scan    = '0;
        if (rst_n) begin
            if (bus.prio0_i && bus.req_i[0]) begin
                gnt[0]  = 1'b1;
                any_gnt = 1'b1;
            end else begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                    if (scan >= (PTR_W+1)'(NUM_PORTS))
                        scan = scan - (PTR_W+1)'(NUM_PORTS);
                    if (!any_gnt && bus.req_i[scan[PTR_W-1:0]]) begin
                        gnt[scan[PTR_W-1:0]] = 1'b1;
                        gidx                 = scan[PTR_W-1:0];
                        any_gnt              = 1'b1;
                    end
                end
            end
        end
    end

    // Override wins also advance the pointer so port 0 cannot re-win right after.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt)
            rr_ptr_d = (gidx == PTR_W'(NUM_PORTS-1)) ? '0 : gidx + 1'b1;
    end

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            stall_d[k] = stall_q[k];
            if (bus.req_i[k] && !gnt[k] && stall_q[k] != {CNT_WIDTH{1'b1}})
                stall_d[k] = stall_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            rvalid_q <= '0;
            stall_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= gnt;
            stall_q  <= stall_d;
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.mem_req_o   = any_gnt;
    assign bus.mem_addr_o  = any_gnt ? bus.addr_i[gidx]  : '0;
    assign bus.mem_we_o    = any_gnt ? bus.we_i[gidx]    : 1'b0;
    assign bus.mem_be_o    = any_gnt ? bus.be_i[gidx]    : {BE_W{1'b0}};
    assign bus.mem_wdata_o = any_gnt ? bus.wdata_i[gidx] : '0;
    assign bus.rvalid_o    = rvalid_q;
    assign bus.rdata_o     = bus.mem_rdata_i;
    assign bus.stall_cnt_o = stall_q;
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares one single-port data RAM between NUM_PORTS requesters, for example the AXI memory interface and a debug/DMA port.
- Sits between the requester-side memory interfaces and the RAM instance.
- Each requester uses a req/gnt/rvalid protocol; the RAM has fixed 1-cycle read latency.
- Arbitration is round-robin, with an optional fixed-priority override for port 0.
- Also provides saturating per-port stall counters for performance debug.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_WIDTH, 16, RAM word-address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.
- CNT_WIDTH, 16, width of each stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- prio0_i  in  1  when high, port 0 wins any conflict (fixed priority).
- req_i  in  NUM_PORTS  per-port request.
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address; port k occupies slice k.
- we_i  in  NUM_PORTS  per-port write enable.
- be_i  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- gnt_o  out  NUM_PORTS  per-port grant, combinational, one-hot or zero.
- rvalid_o  out  NUM_PORTS  per-port response valid.
- rdata_o  out  DATA_WIDTH  shared read data; qualified by rvalid_o.
- mem_req_o  out  1  RAM enable.
- mem_addr_o  out  ADDR_WIDTH  RAM address.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables.
- mem_wdata_o  out  DATA_WIDTH  RAM write data.
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid 1 cycle after mem_req_o.
- stall_cnt_o  out  NUM_PORTS*CNT_WIDTH  per-port count of cycles with req high and gnt low.

Behaviour:
- Reset (rst_n sampled low at posedge clk):
  - rr_ptr = 0, so port 0 is highest priority first.
  - rvalid_o = 0, resp_port = 0, stall_cnt_o = 0.
  - While rst_n is low, gnt_o = 0 and mem_req_o = 0 regardless of req_i.
- Arbitration (combinational, same cycle as req):
  - If prio0_i = 1 and req_i[0] = 1: grant port 0.
  - Otherwise grant the first requesting port scanning rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - No request: gnt_o = 0 and mem_req_o = 0.
  - Exactly one grant per cycle. A grant is never issued to a port whose req is low.
- Memory drive:
  - mem_req_o = |gnt_o.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are muxed from the granted port.
  - When no port is granted they are 0.
- Pointer update:
  - On any grant to port g, rr_ptr <= (g+1) mod NUM_PORTS at the next edge.
  - Grants won through the prio0_i override also update rr_ptr, which prevents port 0 re-winning round-robin immediately after the override drops.
- Response:
  - A grant to port g in cycle N gives rvalid_o[g] = 1 in cycle N+1, for both reads and writes.
  - For reads, rdata_o = mem_rdata_i in cycle N+1. For writes, rdata_o is don't-care.
  - rvalid_o is a registered one-hot copy of gnt_o.
- Back-to-back grants are allowed every cycle, to the same or different ports. Throughput is 1 access per cycle.
- Requester rule: req/addr/we/be/wdata stay stable while req is high and gnt is low. The arbiter does not check this.
- Stall counters:
  - stall_cnt[k] increments each cycle that req_i[k] = 1 and gnt_o[k] = 0.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
  - Cleared only by reset.
- Fairness: with all ports requesting continuously and prio0_i = 0, each port is granted exactly once every NUM_PORTS cycles.
- Reset mid-transaction: a pending rvalid is dropped (rvalid_o = 0 the cycle after reset is sampled) and the pointer returns to 0.

Test Plan:
- Single port: port 1 reads addr 0x0010 (RAM preloaded 0xDEADBEEF).
  - Response: gnt_o = 2'b10 in the same cycle, mem_addr_o = 0x0010.
  - Next cycle: rvalid_o = 2'b10, rdata_o = 0xDEADBEEF.
- Conflict round-robin: both ports request continuously for 6 cycles after reset.
  - Response: grants alternate 01,10,01,10,01,10.
  - stall_cnt for each port ends at 3.
- Write then read: port 0 writes 0x12345678 with be = 4'b0011 to 0x0020 (old value 0xFFFFFFFF), then reads it back.
  - Response: rdata_o = 0xFFFF5678. rvalid is seen after both the write and the read.
- Priority override: prio0_i = 1, both ports requesting for 4 cycles, then prio0_i = 0.
  - Response: port 0 is granted for all 4 cycles and port 1's stall count reaches 4.
  - The next grant goes to port 1.
- Saturation (CNT_WIDTH = 4): port 1 is starved by prio0_i for 20 cycles.
  - Response: stall_cnt[1] = 15 and holds there.
- Reset mid-operation: rst_n is low in the cycle after a read grant to port 1.
  - Response: rvalid_o = 0 and stall counters = 0.
  - First grant after reset, with both ports requesting, goes to port 0.
